// File: rtl/spi_byte_serializer_if.sv
// rtl/spi_byte_serializer_if.sv - word load handshake between upstream and the serializer
interface spi_byte_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/spi_byte_serializer.sv
// rtl/spi_byte_serializer.sv - parallel-to-serial transmitter with one-entry holding buffer and idle fill
module spi_byte_serializer #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'h9F),
   parameter bit               LSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bit_en,
   spi_byte_serializer_if.slave  s_if,
   output logic                  sout,
   output logic                  busy,
   output logic                  byte_done,
   output logic                  underrun
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shift;
   logic [WIDTH-1:0] hold;
   logic [CW-1:0]    cnt;
   logic             hold_full;
   logic             cur_data;
   logic             streaming;
   logic             boundary;
   logic             accept;
   logic             bypass;

   // A boundary frees the hold slot in the same cycle, so upstream may refill it with no bubble.
   always_comb begin
      boundary        = bit_en && (cnt == LAST);
      s_if.data_ready = !hold_full || boundary;
      accept          = s_if.data_valid && s_if.data_ready;
      bypass          = boundary && !hold_full && s_if.data_valid;
      if (LSB_FIRST)
         sr_shift = {1'b0, sr[WIDTH-1:1]};
      else
         sr_shift = {sr[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr        <= IDLE_WORD;
         cnt       <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         cur_data  <= 1'b0;
         streaming <= 1'b0;
         byte_done <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         byte_done <= boundary && cur_data;
         underrun  <= boundary && !hold_full && !s_if.data_valid && streaming;

         if (accept)
            streaming <= 1'b1;

         if (boundary) begin
            cnt <= '0;
            if (hold_full) begin
               sr       <= hold;
               cur_data <= 1'b1;
            end else if (s_if.data_valid) begin
               sr       <= s_if.data_in;
               cur_data <= 1'b1;
            end else begin
               sr       <= IDLE_WORD;
               cur_data <= 1'b0;
            end
         end else if (bit_en) begin
            sr  <= sr_shift;
            cnt <= cnt + CW'(1);
         end

         // A bypassed word goes straight to sr; otherwise any accepted word lands in hold.
         if (accept && !bypass) begin
            hold      <= s_if.data_in;
            hold_full <= 1'b1;
         end else if (boundary) begin
            hold_full <= 1'b0;
         end
      end
   end

   assign sout = LSB_FIRST ? sr[0] : sr[WIDTH-1];
   assign busy = cur_data || hold_full;

endmodule

// File: tb/tb_spi_byte_serializer.sv
// tb/tb_spi_byte_serializer.sv - randomized self-checking bench against a frame-level reference model
module tb_spi_byte_serializer;

   localparam int         W    = 8;
   localparam logic [7:0] IDLE = 8'h9F;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, bit_en, sout, busy, byte_done, underrun;
   logic b_reset, b_bit_en, b_sout, b_busy, b_byte_done, b_underrun;

   spi_byte_serializer_if #(.WIDTH(8)) a_if ();
   spi_byte_serializer_if #(.WIDTH(4)) b_if ();

   spi_byte_serializer #(.WIDTH(8), .IDLE_WORD(8'h9F), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .bit_en(bit_en), .s_if(a_if),
      .sout(sout), .busy(busy), .byte_done(byte_done), .underrun(underrun)
   );

   spi_byte_serializer #(.WIDTH(4), .IDLE_WORD(4'h9), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .reset(b_reset), .bit_en(b_bit_en), .s_if(b_if),
      .sout(b_sout), .busy(b_busy), .byte_done(b_byte_done), .underrun(b_underrun)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Frame-level reference: the word on the wire, bit position within it, and a pending-word queue.
   int   m_frame, m_pos;
   bit   m_is_data, m_stream, m_done, m_under;
   int   m_pend[$];

   task automatic model_reset();
      m_frame = IDLE; m_pos = 0; m_is_data = 0; m_stream = 0;
      m_done = 0; m_under = 0; m_pend.delete();
   endtask

   logic o_sout, o_busy, o_done, o_under, o_ready;

   task automatic step(input bit be, input bit dv, input logic [7:0] d, input bit rst, output bit acc);
      bit bnd, rdy, byp;
      bit_en = be; a_if.data_valid = dv; a_if.data_in = d; reset = rst;
      #3;
      bnd = be && (m_pos == W - 1);
      rdy = (m_pend.size() == 0) || bnd;
      o_sout = sout; o_busy = busy; o_done = byte_done; o_under = underrun; o_ready = a_if.data_ready;
      check("data_ready", o_ready, rdy);
      check("sout", o_sout, (m_frame >> m_pos) & 1);
      check("busy", o_busy, m_is_data || (m_pend.size() != 0));
      check("byte_done", o_done, m_done);
      check("underrun", o_under, m_under);
      acc = dv && rdy && !rst;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         byp = 0;
         m_done = bnd && m_is_data;
         m_under = 0;
         if (bnd) begin
            m_pos = 0;
            if (m_pend.size() > 0) begin
               m_frame = m_pend.pop_front(); m_is_data = 1;
            end else if (dv) begin
               m_frame = d; m_is_data = 1; byp = 1;
            end else begin
               m_frame = IDLE; m_is_data = 0; m_under = m_stream;
            end
         end else if (be) begin
            m_pos++;
         end
         if (acc && !byp) m_pend.push_back(d);
         if (acc) m_stream = 1;
      end
      #1;
   endtask

   initial begin
      bit         acc;
      logic [7:0] idle_bits, exp6, bits6;
      int         dones, unders, early, guard;
      logic [7:0] words[$];

      reset = 1; bit_en = 0; a_if.data_valid = 0; a_if.data_in = '0;
      b_reset = 1; b_bit_en = 0; b_if.data_valid = 0; b_if.data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // Idle fill straight out of reset
      step(0, 0, 8'h00, 0, acc);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 8'h00, 0, acc);
         idle_bits[i] = o_sout;
      end
      check("idle_word", idle_bits, 8'h9F);

      // Single word written mid idle frame
      for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, acc);
      step(0, 1, 8'hA5, 0, acc);
      check("a5_accept", acc, 1);
      dones = 0; unders = 0;
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 8'h00, 0, acc);
         dones += o_done; unders += o_under;
      end
      check("a5_done_cnt", dones, 1);
      check("a5_under_cnt", unders, 1);

      // Back-to-back stream held full by upstream
      words = '{8'h01, 8'h02, 8'h03};
      dones = 0; early = 0; guard = 0;
      while (dones < 3 && guard < 80) begin
         step(1, words.size() > 0, (words.size() > 0) ? words[0] : 8'h00, 0, acc);
         if (acc) void'(words.pop_front());
         if (o_under && dones < 3) early += (o_done ? 0 : 1);
         dones += o_done;
         guard++;
      end
      check("stream_done_cnt", dones, 3);
      check("stream_no_underrun", early, 0);

      // Bypass exactly on a boundary with hold empty
      guard = 0;
      while (m_pos != W - 1 && guard < 20) begin step(1, 0, 8'h00, 0, acc); guard++; end
      step(1, 1, 8'h3C, 0, acc);
      step(0, 0, 8'h00, 0, acc);
      check("bypass_sout", o_sout, 0);
      check("bypass_ready", o_ready, 1);

      // Reset in the middle of an FF frame with 00 held
      guard = 0;
      while (m_pos != W - 1 && guard < 20) begin step(1, 0, 8'h00, 0, acc); guard++; end
      step(1, 1, 8'hFF, 0, acc);
      for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, acc);
      step(0, 1, 8'h00, 0, acc);
      step(0, 0, 8'h00, 1, acc);
      step(0, 0, 8'h00, 0, acc);
      check("rst_sout", o_sout, 1);
      check("rst_busy", o_busy, 0);
      check("rst_ready", o_ready, 1);
      dones = 0;
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 8'h00, 0, acc);
         dones += o_done;
      end
      check("rst_no_done", dones, 0);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 8'($urandom),
              $urandom_range(0, 249) == 0, acc);
      end

      // MSB-first, 4-bit instance
      exp6 = 8'b1001_1100;
      b_reset = 0;
      for (int i = 0; i < 9; i++) begin
         b_bit_en = 1;
         b_if.data_valid = (i == 0);
         b_if.data_in = 4'hC;
         #3;
         bits6[0] = b_sout;
         if (i < 8) check($sformatf("msb_bit%0d", i), bits6[0], exp6[7-i]);
         if (i == 0) check("msb_ready", b_if.data_ready, 1);
         if (i == 8) begin
            check("msb_done", b_byte_done, 1);
            check("msb_underrun", b_underrun, 1);
         end
         @(posedge clk);
         #1;
      end
      b_bit_en = 0; b_if.data_valid = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
